// File: rtl/cmos_frame_crop.sv
// Crops a fixed window out of the packed RGB565 camera stream and hands the kept
// pixels downstream as a valid/ready stream with SOF (m_tuser) and EOL (m_tlast).
module cmos_frame_crop #(
    parameter int X_START = 0,
    parameter int Y_START = 0,
    parameter int CROP_W  = 640,
    parameter int CROP_H  = 480,
    parameter int FIFO_AW = 4
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        vs_i,
    input  logic        de_i,
    input  logic        pix_vld_i,
    input  logic [15:0] pix_data_i,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic [15:0] m_tdata,
    output logic        m_tuser,
    output logic        m_tlast,
    output logic        frame_done,
    output logic        ovf_o
);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam logic [1:0] S_WAIT_VS = 2'd0;
    localparam logic [1:0] S_ACTIVE  = 2'd1;
    localparam logic [1:0] S_DROP    = 2'd2;

    localparam logic [12:0]        X_LO     = 13'(X_START);
    localparam logic [12:0]        X_HI     = 13'(X_START + CROP_W);
    localparam logic [11:0]        Y_LO     = 12'(Y_START);
    localparam logic [11:0]        Y_HI     = 12'(Y_START + CROP_H);
    localparam logic [11:0]        X_FIRST  = 12'(X_START);
    localparam logic [11:0]        X_EOL    = 12'(X_START + CROP_W - 1);
    localparam logic [10:0]        Y_FIRST  = 11'(Y_START);
    localparam logic [10:0]        Y_LAST   = 11'(Y_START + CROP_H - 1);
    localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW + 1)'(DEPTH);

    logic [1:0]         state_q, state_d;
    logic [11:0]        x_q, x_d;
    logic [10:0]        y_q, y_d;
    logic               vs_d_q, de_d_q;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   cnt_q, cnt_d;
    logic [17:0]        mem [DEPTH];
    logic [17:0]        head;

    logic vs_rise, de_fall, in_win, keep, full, pop, push, drop, sof, eol, last_px;

    assign vs_rise = vs_i & ~vs_d_q;
    assign de_fall = ~de_i & de_d_q;
    assign in_win  = ({1'b0, x_q} >= X_LO) && ({1'b0, x_q} < X_HI) &&
                     ({1'b0, y_q} >= Y_LO) && ({1'b0, y_q} < Y_HI);
    // A pixel arriving on the vsync edge belongs to no frame yet, so it is ignored.
    assign keep    = (state_q == S_ACTIVE) && pix_vld_i && in_win && !vs_rise;
    assign full    = (cnt_q == CNT_FULL);
    assign pop     = (cnt_q != '0) && m_tready;
    assign push    = keep && (!full || pop);
    assign drop    = keep && full && !pop;
    assign sof     = (x_q == X_FIRST) && (y_q == Y_FIRST);
    assign eol     = (x_q == X_EOL);
    assign last_px = push && eol && (y_q == Y_LAST);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        ovf_d   = ovf_q;
        done_d  = last_px;
        if (de_fall) begin
            x_d = '0;
            if ((x_q != '0) && (y_q != '1))
                y_d = y_q + 1'b1;
        end else if (pix_vld_i && (x_q != '1)) begin
            x_d = x_q + 1'b1;
        end
        if (state_q == S_ACTIVE) begin
            if (drop) begin
                state_d = S_DROP;
                ovf_d   = 1'b1;
            end else if (last_px) begin
                state_d = S_WAIT_VS;
            end
        end
        if (vs_rise) begin
            state_d = S_ACTIVE;
            x_d     = '0;
            y_d     = '0;
            ovf_d   = 1'b0;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push)
            wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)
            rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)
            cnt_d = cnt_q + 1'b1;
        else if (pop && !push)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q  <= S_WAIT_VS;
            x_q      <= '0;
            y_q      <= '0;
            vs_d_q   <= 1'b0;
            de_d_q   <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            vs_d_q   <= vs_i;
            de_d_q   <= de_i;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is flop-based so the head entry is visible the cycle after the push.
    always_ff @(posedge pclk) begin
        if (push)
            mem[wr_ptr_q] <= {sof, eol, pix_data_i};
    end

    assign head       = mem[rd_ptr_q];
    assign m_tvalid   = (cnt_q != '0);
    assign m_tdata    = m_tvalid ? head[15:0] : 16'h0000;
    assign m_tlast    = m_tvalid & head[16];
    assign m_tuser    = m_tvalid & head[17];
    assign frame_done = done_q;
    assign ovf_o      = ovf_q;

endmodule

// File: tb/tb_cmos_frame_crop.sv
// Directed bench for cmos_frame_crop: an 8x4 image cropped to 4x2 at (2,1), checked
// beat-by-beat against a window model driven alongside the stimulus.
module tb_cmos_frame_crop;
    localparam int X0 = 2, Y0 = 1, CW = 4, CH = 2, AW = 2;
    localparam int IMG_W = 8, IMG_H = 4;
    localparam int DEPTH = 2 ** AW;

    logic        pclk = 1'b0;
    logic        rst, vs_i, de_i, pix_vld_i, m_tready;
    logic [15:0] pix_data_i, m_tdata;
    logic        m_tvalid, m_tuser, m_tlast, frame_done, ovf_o;

    int vectors = 0, miscompares = 0;
    int tready_mode = 1;   // 0 hold low, 1 hold high, 2 toggle every cycle

    logic [17:0] exp_q[$];
    logic [17:0] log_q[$];
    bit          log_en = 1'b0;
    bit          m_active = 1'b0;
    int          m_kept = 0, m_cap = 1 << 30, exp_done = 0, done_cnt = 0;

    cmos_frame_crop #(.X_START(X0), .Y_START(Y0), .CROP_W(CW), .CROP_H(CH), .FIFO_AW(AW)) dut (
        .pclk(pclk), .rst(rst), .vs_i(vs_i), .de_i(de_i), .pix_vld_i(pix_vld_i),
        .pix_data_i(pix_data_i), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
        .m_tuser(m_tuser), .m_tlast(m_tlast), .frame_done(frame_done), .ovf_o(ovf_o)
    );

    always #5 pclk = ~pclk;

    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge pclk);
            #1;
            case (tready_mode)
                0:       m_tready = 1'b0;
                1:       m_tready = 1'b1;
                default: m_tready = ~m_tready;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // Output monitor: every accepted beat must be the oldest modelled beat.
    bit          prev_stall = 1'b0;
    logic [17:0] prev_beat = '0;
    initial begin
        forever begin
            @(negedge pclk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall)
                    check("stall_hold", {13'd0, m_tvalid, m_tuser, m_tlast, m_tdata}, {13'd0, 1'b1, prev_beat});
                if (m_tvalid && m_tready) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_beat: got %h, expected no beat", {m_tuser, m_tlast, m_tdata});
                    end else begin
                        check("beat", {14'd0, m_tuser, m_tlast, m_tdata}, {14'd0, exp_q.pop_front()});
                    end
                    if (log_en)
                        log_q.push_back({m_tuser, m_tlast, m_tdata});
                end
                if (frame_done)
                    done_cnt++;
                prev_stall = m_tvalid && !m_tready;
                prev_beat  = {m_tuser, m_tlast, m_tdata};
            end
        end
    end

    task automatic vs_pulse();
        @(posedge pclk); #1; vs_i = 1'b1;
        repeat (2) @(posedge pclk);
        #1; vs_i = 1'b0;
        repeat (2) @(posedge pclk);
        m_active = 1'b1;
        m_kept   = 0;
    endtask

    task automatic send_row(input int r, input int len, input bit end_line, input int seed);
        @(posedge pclk); #1; de_i = 1'b1;
        for (int c = 0; c < len; c++) begin
            @(posedge pclk); #1;
            pix_vld_i  = 1'b1;
            pix_data_i = {4'(seed), 4'(r), 8'(c)};
            if (m_active && c >= X0 && c < X0 + CW && r >= Y0 && r < Y0 + CH) begin
                if (m_kept >= m_cap) begin
                    m_active = 1'b0;
                end else begin
                    exp_q.push_back({(c == X0 && r == Y0), (c == X0 + CW - 1), pix_data_i});
                    m_kept++;
                    if (c == X0 + CW - 1 && r == Y0 + CH - 1) begin
                        exp_done++;
                        m_active = 1'b0;
                    end
                end
            end
            @(posedge pclk); #1; pix_vld_i = 1'b0;
        end
        if (end_line) begin
            @(posedge pclk); #1; de_i = 1'b0;
            repeat (3) @(posedge pclk);
        end
    endtask

    task automatic send_frame(input int rows, input int short_row, input int short_len, input int seed);
        assert (X0 + CW <= IMG_W) else $error("crop window wider than the line");
        vs_pulse();
        for (int r = 0; r < rows; r++)
            send_row(r, (r == short_row) ? short_len : IMG_W, 1'b1, seed);
    endtask

    task automatic wait_drain(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(posedge pclk); #2;
            if (exp_q.size() == 0 && !m_tvalid)
                ok = 1'b1;
        end
        repeat (2) @(posedge pclk);
        check(name, {31'd0, ok}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; vs_i = 1'b0; de_i = 1'b0; pix_vld_i = 1'b0; pix_data_i = '0;
        repeat (3) @(posedge pclk);
        #1;
        check("reset_outputs", {13'd0, m_tvalid, m_tuser, m_tlast, frame_done, ovf_o, m_tdata}, 32'd0);
        rst = 1'b0;

        // 1: full frame, tready high, log the beats to pin the model with literals
        tready_mode = 1;
        log_en = 1'b1;
        send_frame(IMG_H, -1, 0, 1);
        wait_drain("drain_t1");
        log_en = 1'b0;
        check("t1_beat_count", log_q.size(), 32'd8);
        if (log_q.size() >= 8) begin
            check("t1_beat0", {14'd0, log_q[0]}, {14'd0, 2'b10, 16'h1102});
            check("t1_beat3", {14'd0, log_q[3]}, {14'd0, 2'b01, 16'h1105});
            check("t1_beat4", {14'd0, log_q[4]}, {14'd0, 2'b00, 16'h1202});
            check("t1_beat7", {14'd0, log_q[7]}, {14'd0, 2'b01, 16'h1205});
        end
        check("t1_frame_done", done_cnt, 32'd1);
        check("t1_ovf", {31'd0, ovf_o}, 32'd0);

        // 2: toggling tready, stalls checked by the monitor
        tready_mode = 2;
        send_frame(IMG_H, -1, 0, 2);
        wait_drain("drain_t2");
        tready_mode = 1;
        check("t2_frame_done", done_cnt, exp_done);

        // 3: no drain for the whole frame, only DEPTH beats survive
        tready_mode = 0;
        m_cap = DEPTH;
        send_frame(IMG_H, -1, 0, 3);
        check("t3_queued", exp_q.size(), DEPTH);
        check("t3_ovf_set", {31'd0, ovf_o}, 32'd1);
        tready_mode = 1;
        wait_drain("drain_t3a");
        check("t3_ovf_sticky", {31'd0, ovf_o}, 32'd1);
        m_cap = 1 << 30;
        send_frame(IMG_H, -1, 0, 5);
        wait_drain("drain_t3b");
        check("t3_ovf_cleared", {31'd0, ovf_o}, 32'd0);
        check("t3_frame_done", done_cnt, exp_done);

        // 4: reset mid-line while beats are queued
        tready_mode = 0;
        vs_pulse();
        send_row(0, IMG_W, 1'b1, 6);
        send_row(1, 4, 1'b0, 6);
        check("t4_queued_before_rst", {31'd0, m_tvalid}, 32'd1);
        @(posedge pclk); #3;
        rst = 1'b1;
        #1;
        check("t4_async_clear", {13'd0, m_tvalid, m_tuser, m_tlast, frame_done, ovf_o, m_tdata}, 32'd0);
        exp_q.delete();
        m_active = 1'b0;
        de_i = 1'b0; pix_vld_i = 1'b0;
        repeat (2) @(posedge pclk);
        #1; rst = 1'b0;
        tready_mode = 1;
        for (int r = 0; r < IMG_H; r++)
            send_row(r, IMG_W, 1'b1, 7);
        repeat (4) @(posedge pclk);
        #2;
        check("t4_silent_without_vs", {31'd0, m_tvalid}, 32'd0);
        send_frame(IMG_H, -1, 0, 8);
        wait_drain("drain_t4");
        check("t4_frame_done", done_cnt, exp_done);

        // 5: frame aborted after row 1, then a fresh frame
        send_frame(2, -1, 0, 9);
        send_frame(IMG_H, -1, 0, 10);
        wait_drain("drain_t5");
        check("t5_frame_done", done_cnt, exp_done);

        // 6: short row 1 (3 pixels), row 2 normal
        send_frame(IMG_H, 1, 3, 11);
        wait_drain("drain_t6");
        check("t6_frame_done", done_cnt, exp_done);
        check("t6_total_done", done_cnt, 32'd6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
